// File: rtl/rot_share_pkg.sv
// Shared types and derivation helpers for the rotator-sharing arbiter.
package rot_share_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_N_REQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int calc_aw(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rot_core.sv
// Combinational log-stage rotator; stage gi rotates by 2**gi when amt[gi] is set.
// Optional ROT_SHARE_DIR_EN adds a dir input (1 = rotate left, 0 = rotate right).
module rot_core
    import rot_share_pkg::*;
#(
    parameter int W  = DEF_W,
    localparam int AW = calc_aw(W)
) (
    input  logic [W-1:0]  data,
    input  logic [AW-1:0] amt,
`ifdef ROT_SHARE_DIR_EN
    input  logic          dir,
`endif
    output logic [W-1:0]  result
);

    logic [W-1:0] stage [AW+1];

    assign stage[0] = data;

    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_stage
            localparam int SH = 2 ** gi;
            logic [W-1:0] rot_r;
            logic [W-1:0] rot_l;
            assign rot_r = (stage[gi] >> SH) | (stage[gi] << (W - SH));
            assign rot_l = (stage[gi] << SH) | (stage[gi] >> (W - SH));
`ifdef ROT_SHARE_DIR_EN
            assign stage[gi+1] = !amt[gi] ? stage[gi] : (dir ? rot_l : rot_r);
`else
            assign stage[gi+1] = amt[gi] ? rot_r : stage[gi];
`endif
        end
    endgenerate

    assign result = stage[AW];

endmodule

// File: rtl/rot_share_arb.sv
// Round-robin arbiter feeding one shared rotator into a single-entry output stage.
// Optional ROT_SHARE_DIR_EN adds per-request direction (req_dir) and echoes it on rsp_dir.
module rot_share_arb
    import rot_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    localparam int AW   = calc_aw(W),
    localparam int IDW  = calc_idw(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*W-1:0]  req_data,
    input  logic [N_REQ*AW-1:0] req_amt,
`ifdef ROT_SHARE_DIR_EN
    input  logic [N_REQ-1:0]    req_dir,
    output logic                rsp_dir,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_data,
    output logic [IDW-1:0]      rsp_id
);

    state_t         state_reg;
    logic [IDW-1:0] rr_ptr_reg;
    logic           rsp_valid_reg;
    logic [W-1:0]   rsp_data_reg;
    logic [IDW-1:0] rsp_id_reg;

    logic           found;
    logic [IDW-1:0] grant;
    logic           can_accept;
    logic           xfer;
    logic [W-1:0]   sel_data;
    logic [AW-1:0]  sel_amt;
    logic [W-1:0]   rot_result;

    // Scan from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                grant = idx[IDW-1:0];
            end
        end
    end

    assign can_accept = (state_reg == IDLE) || rsp_ready;
    // Gated by rst so nothing is offered while reset is held.
    assign xfer       = found && can_accept && !rst;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[grant] = 1'b1;
    end

    assign sel_data = req_data[int'(grant)*W +: W];
    assign sel_amt  = req_amt[int'(grant)*AW +: AW];

    rot_core #(.W(W)) u_rot_core (
        .data   (sel_data),
        .amt    (sel_amt),
`ifdef ROT_SHARE_DIR_EN
        .dir    (req_dir[grant]),
`endif
        .result (rot_result)
    );

`ifdef ROT_SHARE_DIR_EN
    logic rsp_dir_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rsp_dir_reg <= 1'b0;
        else if (xfer) rsp_dir_reg <= req_dir[grant];
    end
    assign rsp_dir = rsp_dir_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
        end else begin
            if (xfer) begin
                rsp_data_reg <= rot_result;
                rsp_id_reg   <= grant;
                if (int'(grant) == N_REQ - 1) rr_ptr_reg <= '0;
                else                          rr_ptr_reg <= grant + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (xfer) begin
                        state_reg     <= HOLD;
                        rsp_valid_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    if (rsp_ready && !xfer) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_rot_share_arb.sv
// Directed + random bench for rot_share_arb with a reference arbiter model and result scoreboard.
// Optional ROT_SHARE_DIR_EN: req_dir is tied to 0 so results stay rotate-right.
module tb_rot_share_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N*W-1:0] req_data;
    logic [N*3-1:0] req_amt;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [1:0]   rsp_id;
`ifdef ROT_SHARE_DIR_EN
    logic [N-1:0] req_dir;
    logic         rsp_dir;
`endif

    rot_share_arb #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
`ifdef ROT_SHARE_DIR_EN
        .req_dir   (req_dir),
        .rsp_dir   (rsp_dir),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   id;
    } exp_t;

    exp_t     sb_q[$];
    int       n_cmp = 0;
    int       n_err = 0;
    int       m_ptr = 0;
    bit       m_full = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_rotr(input logic [W-1:0] x, input int amt);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[k] = x[(k + amt) % W];
        return r;
    endfunction

    task automatic set_lane(input int i, input logic [W-1:0] d, input logic [2:0] a);
        req_data[i*W +: W] = d;
        req_amt[i*3 +: 3]  = a;
    endtask

    // One clock: model-check at negedge, advance through posedge, land at posedge+1.
    task automatic cycle();
        bit           can;
        bit           fnd;
        int           g;
        int           idx;
        logic [N-1:0] exp_ready;
        exp_t         e;
        @(negedge clk);
        can = !m_full || rsp_ready;
        fnd = 0;
        g   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!fnd && req_valid[idx]) begin
                fnd = 1;
                g   = idx;
            end
        end
        exp_ready = (fnd && can) ? N'(1 << g) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        if (m_full) begin
            check("rsp_valid", 64'(rsp_valid), 64'd1);
            check("rsp_data", 64'(rsp_data), 64'(sb_q[0].data));
            check("rsp_id", 64'(rsp_id), 64'(sb_q[0].id));
        end else begin
            check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        end
        if (m_full && rsp_ready) void'(sb_q.pop_front());
        if (fnd && can) begin
            e.data = ref_rotr(req_data[g*W +: W], int'(req_amt[g*3 +: 3]));
            e.id   = 2'(g);
            sb_q.push_back(e);
            m_ptr  = (g + 1) % N;
        end
        m_full = (fnd && can) || (m_full && !rsp_ready);
        $display("t=%0t valid=%b ready=%b rsp_v=%b rsp_d=%h rsp_id=%0d", $time,
                 req_valid, req_ready, rsp_valid, rsp_data, rsp_id);
        @(posedge clk);
        #1;
        check("rr_ptr", 64'(dut.rr_ptr_reg), 64'(m_ptr));
    endtask

    int seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_amt   = '0;
        rsp_ready = 1'b1;
`ifdef ROT_SHARE_DIR_EN
        req_dir   = '0;
`endif
        #2 req_valid = 4'hF;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single request
        set_lane(0, 8'hB4, 3'd3);
        req_valid = 4'b0001;
        #1 check("single_ready", 64'(req_ready), 64'b0001);
        cycle();
        req_valid = '0;
        check("single_data", 64'(rsp_data), 64'h96);
        check("single_id", 64'(rsp_id), 64'd0);
        check("single_ptr", 64'(dut.rr_ptr_reg), 64'd1);
        cycle();

        // Bring pointer back to 0 via requester 3
        req_valid = 4'b1000;
        cycle();

        // Fairness
        for (int i = 0; i < N; i++) set_lane(i, 8'h01, 3'd0);
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1 check("fair_grant", 64'(req_ready), 64'(1 << seq[i]));
            cycle();
        end

        // Backpressure
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check("bp_hold_id", 64'(rsp_id), 64'd0);
        rsp_ready = 1'b1;
        #1 check("bp_release_grant", 64'(req_ready), 64'b0010);
        cycle();

        // Pointer wrap and skip
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'b0110;
        #1 check("wrap_grant1", 64'(req_ready), 64'b0010);
        cycle();
        #1 check("wrap_grant2", 64'(req_ready), 64'b0100);
        cycle();

        // Rotate boundaries
        set_lane(0, 8'hA5, 3'd0);
        set_lane(1, 8'h01, 3'd7);
        set_lane(2, 8'h3C, 3'd4);
        req_valid = 4'b0001;
        cycle();
        check("rot_amt0", 64'(rsp_data), 64'hA5);
        req_valid = 4'b0010;
        cycle();
        check("rot_amt7", 64'(rsp_data), 64'h02);
        req_valid = 4'b0100;
        cycle();
        check("rot_amt4", 64'(rsp_data), 64'hC3);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = $urandom;
            req_amt   = 12'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Reset while holding a result under backpressure
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        set_lane(0, 8'h5A, 3'd1);
        cycle();
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_rsp_data", 64'(rsp_data), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        sb_q.delete();
        m_full = 0;
        m_ptr  = 0;
        #1 check("midrst_ptr", 64'(dut.rr_ptr_reg), 64'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rot_share_arb.md
Name: rot_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one rotate-right datapath among N_REQ requesters.
- Each requester presents a word and a rotate amount over a valid/ready handshake.
- One request is granted per cycle; it is rotated and registered into a single-entry output stage with a valid/ready response handshake.
- Sits between several consumer blocks and the rotator, so only one rotator instance is needed.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, data width; power of two, 8..64.
- AW, $clog2(W), rotate-amount width (derived; not overridden).
- IDW, $clog2(N_REQ), requester-index width (derived).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester grant/accept; one-hot or zero.
- req_data  input  N_REQ*W  packed operands; requester i at [i*W +: W].
- req_amt  input  N_REQ*AW  packed rotate amounts; requester i at [i*AW +: AW].
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_data  output  W  rotated result.
- rsp_id  output  IDW  index of the requester that produced rsp_data.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, state=IDLE. req_ready is combinational and 0 during reset.
- FSM states:
  - IDLE: output stage empty.
  - HOLD: output stage full.
- can_accept = (state==IDLE) | (state==HOLD & rsp_ready).
- Grant: the first requester with req_valid=1, scanning rr_ptr, rr_ptr+1, … mod N_REQ.
- req_ready[g]=1 only for the granted g, and only when can_accept. All other bits are 0.
- Transfer on req_valid[g] & req_ready[g]:
  - Next edge: rsp_data = rotr(req_data[g], req_amt[g]); rsp_id = g; state = HOLD.
  - rr_ptr = (g+1) mod N_REQ; wrap from N_REQ-1 to 0.
- Without a transfer, rr_ptr is unchanged.
- Latency is 1 cycle from accept to rsp_valid. Throughput is 1 per cycle while rsp_ready=1.
- HOLD with rsp_ready=0: rsp_data and rsp_id are held stable, and all req_ready are 0.
- HOLD with rsp_ready=1 and no valid request: state becomes IDLE, rsp_valid=0.
- HOLD with rsp_ready=1 and a valid request: pop and push in the same edge; state stays HOLD with the new data.
- rotr semantics: result bit k = in[(k+amt) mod W]. amt=0 passes data through. No out-of-range amount exists, since AW covers 0..W-1.
- Requesters must hold req_data/req_amt stable while req_valid=1 and not accepted. A requester may drop req_valid before acceptance; it is simply not granted.
- No requester valid: all req_ready=0 and rr_ptr is unchanged.
- Reset mid-operation: a pending result is discarded without handshake, and the pointer returns to 0.

Optional Feature:
- Macro ROT_SHARE_DIR_EN.
- When defined:
  - Adds input port req_dir [N_REQ-1:0], captured with the request.
  - req_dir=1 selects rotate-left (result bit k = in[(k-amt) mod W]); 0 selects rotate-right.
  - Adds output rsp_dir (1 bit), reset 0, echoing the captured direction.
- When undefined:
  - Neither port exists; all operations are rotate-right.
  - Behaviour is otherwise identical.

Decomposition:
- Package rot_share_pkg holds:
  - typedef state_t {IDLE, HOLD};
  - localparam functions for AW/IDW derivation;
  - default W and N_REQ constants.
- One sub-module, rot_core: purely combinational log-stage rotator, parameter W, inputs data/amt (plus dir under ROT_SHARE_DIR_EN), output result.
- Arbitration, FSM and output register stay in rot_share_arb.

Test Plan:
- Reset/single request:
  - Reset, then req_valid=4'b0001, req_data[0]=8'hB4, req_amt[0]=3.
  - Expect: req_ready=4'b0001 in that cycle; next cycle rsp_valid=1, rsp_data=8'h96, rsp_id=0; rr_ptr=1.
- Round-robin fairness:
  - All four requesters held valid with data 8'h01, amt 0, rsp_ready=1.
  - Expect: grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3 matches.
- Backpressure:
  - Fill the output, then hold rsp_ready=0 for 5 cycles with req_valid=4'b1111.
  - Expect: req_ready=0 throughout, rsp_data/rsp_id stable; first cycle after rsp_ready=1 pops and accepts the next requester in the same edge.
- Pointer wrap and skip:
  - rr_ptr=3, req_valid=4'b0110.
  - Expect: grant 1, then rr_ptr=2 and the next grant is 2.
- Rotate boundaries:
  - amt=0 on 8'hA5 gives 8'hA5; amt=7 on 8'h01 gives 8'h02; amt=4 on 8'h3C gives 8'hC3.
- Reset mid-HOLD:
  - Assert rst asynchronously while rsp_valid=1 and rsp_ready=0.
  - Expect: rsp_valid=0 immediately (before the next clk edge), rsp_data=0, rr_ptr=0 after release.
